// File: rtl/dncnt56_reload.sv
// dncnt56_reload: loadable down-counter/timer with borrow and auto-reload.
// Optional prescaler: define DNCNT_PRESCALE_EN to add PRE and counter P.
module dncnt56_reload #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic             MODE,
  input  logic [WIDTH-1:0] DATA,
`ifdef DNCNT_PRESCALE_EN
  input  logic [3:0]       PRE,
`endif
  output logic [WIDTH-1:0] DOUT,
  output logic             BOUT,
  output logic             DONE,
  output logic             BUSY
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           st_q;
  state_t           st_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             done_q;
  logic             done_d;
  logic             tick;
  logic             q_zero;

  assign q_zero = (q_q == '0);

`ifdef DNCNT_PRESCALE_EN
  logic [3:0] p_q;
  logic [3:0] p_d;

  // Prescaler: a step happens only on RUN cycles where P has run out.
  always_comb begin
    p_d  = p_q;
    tick = (p_q == 4'd0);
    if (EN) begin
      if (!LOAD) begin
        p_d = PRE;
      end else if (st_q == RUN) begin
        p_d = tick ? PRE : (p_q - 4'd1);
      end
    end
  end

  // Prescale register; cleared by reset, held while EN is low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_q <= 4'd0;
    end else begin
      p_q <= p_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state: hold, load, count step or terminal event.
  always_comb begin
    st_d   = st_q;
    q_d    = q_q;
    r_d    = r_q;
    done_d = 1'b0;
    if (EN) begin
      if (!LOAD) begin
        q_d  = DATA;
        r_d  = DATA;
        st_d = (DATA != '0) ? RUN : IDLE;
      end else begin
        unique case (st_q)
          RUN: begin
            if (tick) begin
              if (!q_zero) begin
                q_d = q_q - ONE;
              end else begin
                done_d = 1'b1;
                if (MODE) begin
                  q_d = r_q;
                end else begin
                  st_d = IDLE;
                end
              end
            end
          end
          default: begin
            q_d = q_q;
          end
        endcase
      end
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q   <= IDLE;
      q_q    <= '0;
      r_q    <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      q_q    <= q_d;
      r_q    <= r_d;
      done_q <= done_d;
    end
  end

  assign DOUT = q_q;
  assign BOUT = q_zero;
  assign DONE = done_q;
  assign BUSY = (st_q == RUN);

endmodule

// File: tb/tb_dncnt56_reload.sv
// tb_dncnt56_reload: vector table, corner sequences and random vs model.
// Builds with or without DNCNT_PRESCALE_EN.
module tb_dncnt56_reload;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         EN;
  logic         LOAD;
  logic         MODE;
  logic [W-1:0] DATA;
  logic [W-1:0] DOUT;
  logic         BOUT;
  logic         DONE;
  logic         BUSY;
`ifdef DNCNT_PRESCALE_EN
  logic [3:0]   PRE;
`endif

  int npass = 0;
  int ntot  = 0;

  // reference model: phase count since load rather than a register copy
  int m_run;
  int m_n;
  int m_k;
  int m_done;

  dncnt56_reload #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .LOAD(LOAD),
    .MODE(MODE),
    .DATA(DATA),
`ifdef DNCNT_PRESCALE_EN
    .PRE (PRE),
`endif
    .DOUT(DOUT),
    .BOUT(BOUT),
    .DONE(DONE),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int rst;
    int en;
    int load;
    int mode;
    int data;
    int q;
    int b;
    int d;
    int y;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_out(input string nm, input int q, input int b,
                         input int d, input int y);
    chk({nm, ".dout"}, int'(DOUT), q);
    chk({nm, ".bout"}, int'(BOUT), b);
    chk({nm, ".done"}, int'(DONE), d);
    chk({nm, ".busy"}, int'(BUSY), y);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic l,
                       input logic m, input logic [W-1:0] d);
    RST  = r;
    EN   = e;
    LOAD = l;
    MODE = m;
    DATA = d;
  endtask

  task automatic mdl_edge(input logic r, input logic e, input logic l,
                          input logic m, input logic [W-1:0] d);
    if (r) begin
      m_run = 0; m_n = 0; m_k = 0; m_done = 0;
    end else if (!e) begin
      m_done = 0;
    end else if (!l) begin
      m_n = int'(d); m_k = 0; m_done = 0;
      m_run = (d != '0) ? 1 : 0;
    end else if (m_run != 0) begin
      m_done = ((m_k % (m_n + 1)) == m_n) ? 1 : 0;
      if (m_done != 0 && !m) m_run = 0;
      m_k++;
    end else begin
      m_done = 0;
    end
  endtask

  int exp_q;
  int first;
  int cnt;
  string nm;

  initial begin
`ifdef DNCNT_PRESCALE_EN
    PRE = 4'd0;
`endif
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);

    //         rst en ld md data  q  b  d  y
    tbl[0] = '{1, 1, 0, 0, 'h55, 0, 1, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 'h55, 0, 1, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 3,    3, 0, 0, 1};
    tbl[3] = '{0, 1, 1, 0, 0,    2, 0, 0, 1};
    tbl[4] = '{0, 1, 1, 0, 0,    1, 0, 0, 1};
    tbl[5] = '{0, 1, 1, 0, 0,    0, 1, 0, 1};
    tbl[6] = '{0, 1, 1, 0, 0,    0, 1, 1, 0};
    tbl[7] = '{0, 1, 1, 0, 0,    0, 1, 0, 0};
    tbl[8] = '{0, 1, 1, 1, 9,    0, 1, 0, 0};
    tbl[9] = '{0, 1, 0, 0, 0,    0, 1, 0, 0};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rst[0], tbl[i].en[0], tbl[i].load[0],
            tbl[i].mode[0], tbl[i].data[W-1:0]);
      step();
      nm = $sformatf("vec%0d", i);
      chk_out(nm, tbl[i].q, tbl[i].b, tbl[i].d, tbl[i].y);
    end

    // auto-reload: period 3, ten pulses in thirty cycles
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
    step();
    chk_out("ar_load", 2, 0, 0, 1);
    LOAD = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (DONE) cnt++;
      chk($sformatf("ar_dout%0d", i), int'(DOUT), 2 - (i % 3));
      chk($sformatf("ar_done%0d", i), int'(DONE), (i % 3 == 0) ? 1 : 0);
    end
    chk("ar_pulses", cnt, 10);

    // enable gating at DOUT=2
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
    step();
    LOAD = 1'b1;
    step();
    step();
    chk_out("eg_pre", 2, 0, 0, 1);
    EN = 1'b0;
    LOAD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("eg_hold%0d", i), 2, 0, 0, 1);
    end
    EN = 1'b1;
    LOAD = 1'b1;
    step();
    chk_out("eg_res1", 1, 0, 0, 1);
    step();
    chk_out("eg_res0", 0, 1, 0, 1);

    // reload mid-run, load at Q==0, then zero load
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    step();
    LOAD = 1'b1;
    step();
    chk_out("rl_at1", 1, 0, 0, 1);
    LOAD = 1'b0;
    DATA = 8'd7;
    step();
    chk_out("rl_7", 7, 0, 0, 1);
    DATA = 8'd1;
    step();
    LOAD = 1'b1;
    step();
    chk_out("rl_q0", 0, 1, 0, 1);
    LOAD = 1'b0;
    DATA = 8'd5;
    step();
    chk_out("rl_over0", 5, 0, 0, 1);
    DATA = 8'd0;
    step();
    chk_out("rl_zero", 0, 1, 0, 0);
    LOAD = 1'b1;
    step();
    chk_out("rl_zero2", 0, 1, 0, 0);

    // mid-count reset at 0x80, then full 256-cycle period
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
    step();
    LOAD = 1'b1;
    cnt = 0;
    while (DOUT != 8'h80 && cnt < 200) begin
      step();
      cnt++;
    end
    chk("mr_steps", cnt, 127);
    RST = 1'b1;
    step();
    chk_out("mr_rst", 0, 1, 0, 0);
    RST = 1'b0;
    LOAD = 1'b0;
    step();
    LOAD = 1'b1;
    first = -1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (DONE) begin
        first = i;
        break;
      end
    end
    chk("ff_period", first, 256);
    chk("ff_reload", int'(DOUT), 255);

`ifdef DNCNT_PRESCALE_EN
    // prescale by 2: preset 2 finishes after 6 enabled cycles
    PRE = 4'd1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    step();
    LOAD = 1'b1;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (DONE) begin
        first = i;
        break;
      end
    end
    chk("pre_period", first, 6);
    PRE = 4'd0;
`endif

    // random stimulus against the phase model
    for (int i = 0; i < 2000; i++) begin
      logic r, e, l, m;
      logic [W-1:0] d;
      r = (i == 0) || ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 85);
      l = !($urandom_range(0, 99) < 8);
      m = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) d = W'($urandom_range(0, 255));
      else d = W'($urandom_range(0, 6));
      drive(r, e, l, m, d);
      mdl_edge(r, e, l, m, d);
      step();
      exp_q = (m_run != 0) ? (m_n - (m_k % (m_n + 1))) : 0;
      nm = $sformatf("rnd%0d", i);
      chk_out(nm, exp_q, (exp_q == 0) ? 1 : 0, m_done, m_run);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
